bp_table_controller: RTL

Sequencer and arbiter in front of the single-ported branch-predictor counter table (2-bit saturating counters, 2^BPRED_WIDTH entries). Three duties:
- Sweeps every entry to the weakly-taken state after reset or flush.
- Buffers ALU branch resolutions in a small update queue.
- Arbitrates the table port between fetch-stage lookups and queued updates.

It sits between fetch, the ALU resolution path and counter_table.

---
 rtl/bp_pkg.sv | 19 +
 rtl/bp_update_fifo.sv | 64 ++++++
 rtl/bp_table_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor table controller.
package bp_pkg;

    typedef enum logic {
        BP_INIT,
        BP_RUN
    } bp_state_e;

    // Widest table index an update entry can carry.
    localparam int BP_MAX_WIDTH = 16;

    localparam logic [1:0] BP_WEAK_TAKEN = 2'b10;

    typedef struct packed {
        logic [BP_MAX_WIDTH-1:0] index;
        logic                    outcome;
    } bp_upd_t;

endpackage

// File: rtl/bp_update_fifo.sv
// Small circular FIFO buffering branch resolutions until the table port is free.
module bp_update_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + AW'(1);
            if (pop_i)  head_d = head_q + AW'(1);
            if (push_i && !pop_i) count_d = count_q + CW'(1);
            if (!push_i && pop_i) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[tail_q] <= data_i;
    end

    assign data_o  = mem_q[head_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/bp_table_controller.sv
// Init sweep, update queue and port arbiter for the predictor counter table.
// Optional BP_PERF_CNT_EN adds lookup/update/stall counters.
module bp_table_controller
    import bp_pkg::*;
#(
    parameter int BPRED_WIDTH = 9,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   i_Reset,
    input  logic                   i_Flush,
    input  logic                   i_Lookup_Valid,
    input  logic [BPRED_WIDTH-1:0] i_Lookup_Index,
    output logic                   o_Lookup_Ready,
    output logic                   o_Pred_Valid,
    output logic                   o_Pred,
    output logic [BPRED_WIDTH-1:0] o_Pred_Index,
    input  logic                   i_Update_Valid,
    input  logic [BPRED_WIDTH-1:0] i_Update_Index,
    input  logic                   i_Update_Outcome,
    output logic                   o_Update_Ready,
    output logic                   o_Busy,
    output logic [BPRED_WIDTH-1:0] o_Table_Index,
    output logic                   o_Table_Enable,
    output logic                   o_Table_Outcome,
    output logic                   o_Table_Init,
`ifdef BP_PERF_CNT_EN
    output logic [31:0]            o_Cnt_Lookups,
    output logic [31:0]            o_Cnt_Updates,
    output logic [31:0]            o_Cnt_Lookup_Stalls,
`endif
    input  logic                   i_Table_Prediction
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [BPRED_WIDTH-1:0] LAST_IDX = '1;

    bp_state_e              state_q, state_d;
    logic [BPRED_WIDTH-1:0] ptr_q, ptr_d;
    logic                   pred_valid_q, pred_q;
    logic [BPRED_WIDTH-1:0] pred_idx_q;

    logic    ready, lk_grant, push, pop, q_clear;
    logic    q_full, q_empty;
    logic [CW-1:0] q_count;
    bp_upd_t q_wdata, q_head;

    always_comb begin
        q_wdata         = '0;
        q_wdata.index[BPRED_WIDTH-1:0] = i_Update_Index;
        q_wdata.outcome = i_Update_Outcome;
    end

    bp_update_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(bp_upd_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (i_Reset),
        .clear_i (q_clear),
        .push_i  (push),
        .data_i  (q_wdata),
        .pop_i   (pop),
        .data_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        o_Busy          = 1'b0;
        o_Table_Init    = 1'b0;
        o_Table_Index   = i_Lookup_Index;
        o_Table_Enable  = 1'b0;
        o_Table_Outcome = 1'b0;
        ready           = 1'b0;
        lk_grant        = 1'b0;
        pop             = 1'b0;
        q_clear         = 1'b0;
        unique case (state_q)
            BP_INIT: begin
                o_Busy        = 1'b1;
                o_Table_Init  = 1'b1;
                o_Table_Index = ptr_q;
                if (i_Flush) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST_IDX) begin
                    ptr_d   = '0;
                    state_d = BP_RUN;
                end else begin
                    ptr_d = ptr_q + BPRED_WIDTH'(1);
                end
            end
            BP_RUN: begin
                ready    = !q_full && !i_Flush;
                lk_grant = i_Lookup_Valid && ready;
                // Flush wins over both lookup and pending update.
                if (i_Flush) begin
                    state_d = BP_INIT;
                    ptr_d   = '0;
                    q_clear = 1'b1;
                end else if (!lk_grant && !q_empty) begin
                    o_Table_Enable  = 1'b1;
                    o_Table_Index   = q_head.index[BPRED_WIDTH-1:0];
                    o_Table_Outcome = q_head.outcome;
                    pop             = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign o_Lookup_Ready = ready;
    assign o_Update_Ready = ready;
    assign push           = i_Update_Valid && ready;

    always_ff @(posedge clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= BP_INIT;
            ptr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_q       <= 1'b0;
            pred_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pred_valid_q <= lk_grant;
            if (lk_grant) begin
                pred_q     <= i_Table_Prediction;
                pred_idx_q <= i_Lookup_Index;
            end
        end
    end

    assign o_Pred_Valid = pred_valid_q;
    assign o_Pred       = pred_q;
    assign o_Pred_Index = pred_idx_q;

`ifdef BP_PERF_CNT_EN
    logic [31:0] cnt_lk_q, cnt_up_q, cnt_st_q;
    logic        stall;

    assign stall = (state_q == BP_RUN) && i_Lookup_Valid && !ready;

    always_ff @(posedge clk or posedge i_Reset) begin
        if (i_Reset) begin
            cnt_lk_q <= '0;
            cnt_up_q <= '0;
            cnt_st_q <= '0;
        end else begin
            if (lk_grant) cnt_lk_q <= cnt_lk_q + 32'd1;
            if (pop)      cnt_up_q <= cnt_up_q + 32'd1;
            if (stall)    cnt_st_q <= cnt_st_q + 32'd1;
        end
    end

    assign o_Cnt_Lookups       = cnt_lk_q;
    assign o_Cnt_Updates       = cnt_up_q;
    assign o_Cnt_Lookup_Stalls = cnt_st_q;
`endif

endmodule
